biquad_notch_tdm: RTL and testbench

Parametrised, time-multiplexed second-order IIR (biquad) notch filter serving `CH` independent channels through one shared multiply-accumulate unit. It adds run-time loadable coefficients, Q-format rounding and saturation, valid/ready handshakes and a per-sample saturation flag. It sits between the modulator front end and the DEM switch-block path, shaping each channel's noise before element selection.

---
 rtl/lib_switchblock_pkg.sv | 24 ++
 rtl/biquad_mac.sv | 45 ++++
 rtl/biquad_notch_tdm.sv | 184 ++++++++++++++++++
 tb/tb_biquad_notch_tdm.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// Shared definitions for the biquad notch block: FSM states, coefficient slots
// and the pass-through coefficient set loaded at reset.
package lib_switchblock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int NUM_COEF = 5;

    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    // b0 = 1.0, everything else 0: the filter passes samples straight through.
    function automatic int default_coef(input logic [2:0] idx, input int frac_w);
        return (idx == COEF_B0) ? (1 << frac_w) : 0;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// One multiply-accumulate step of the biquad plus round-half-up and clip of the
// running sum, so the last step of a sample directly yields the output value.
module biquad_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 18,
    parameter int FRAC_W = 14,
    parameter int ACC_W  = DATA_W + COEF_W + 3
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic                     sub_i,
    output logic signed [ACC_W-1:0]  acc_o,
    output logic signed [DATA_W-1:0] y_o,
    output logic                     sat_o
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(2 ** (FRAC_W - 1));
    localparam logic signed [ACC_W-1:0] MAX_Y = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_Y = ~MAX_Y;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  rnd;

    assign prod     = PROD_W'(coef_i) * PROD_W'(data_i);
    assign prod_ext = ACC_W'(prod);
    assign acc_o    = sub_i ? (acc_i - prod_ext) : (acc_i + prod_ext);
    assign biased   = acc_o + HALF;
    assign rnd      = biased >>> FRAC_W;

    always_comb begin
        sat_o = 1'b0;
        y_o   = rnd[DATA_W-1:0];
        if (rnd > MAX_Y) begin
            y_o   = MAX_Y[DATA_W-1:0];
            sat_o = 1'b1;
        end else if (rnd < MIN_Y) begin
            y_o   = MIN_Y[DATA_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/biquad_notch_tdm.sv
// Time-multiplexed Direct Form I biquad: one shared MAC walks b0,b1,b2,a1,a2 for
// each accepted sample, with per-channel history and double-banked coefficients.
module biquad_notch_tdm
    import lib_switchblock_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int COEF_W = 18,
    parameter  int FRAC_W = 14,
    parameter  int CH     = 4,
    parameter  int ACC_W  = DATA_W + COEF_W + 3,
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              bypass_i,
    input  logic              coef_we_i,
    input  logic [2:0]        coef_idx_i,
    input  logic [COEF_W-1:0] coef_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic [CH_W-1:0]   s_ch_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [CH_W-1:0]   m_ch_o,
    output logic              sat_o,
    output logic              ch_err_o
);
    state_e                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_sum;
    logic signed [DATA_W-1:0]  x_q, m_data_q, y_mac, mac_opnd;
    logic signed [COEF_W-1:0]  mac_coef;
    logic [CH_W-1:0]           ch_q, m_ch_q;
    logic                      bypass_q, flush_pend_q, sat_q, ch_err_q;
    logic                      mac_sub, sat_mac;
    logic                      ch_ok, accept, take, flush_now, wb;

    logic signed [COEF_W-1:0]  active_coef [NUM_COEF];
    logic signed [DATA_W-1:0]  x1_rd [CH];
    logic signed [DATA_W-1:0]  x2_rd [CH];
    logic signed [DATA_W-1:0]  y1_rd [CH];
    logic signed [DATA_W-1:0]  y2_rd [CH];

    assign ch_ok     = int'(s_ch_i) < CH;
    assign accept    = (state_q == ST_IDLE) && s_valid_i;
    assign take      = accept && ch_ok;
    assign flush_now = (state_q == ST_IDLE) && (flush_i || flush_pend_q);
    assign wb        = (state_q == ST_OUT) && m_ready_i;

    // Shadow bank takes writes at any time; the active bank only moves on acceptance.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEF; gi++) begin : g_coef
            logic signed [COEF_W-1:0] shadow_q, active_q;
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    shadow_q <= COEF_W'(default_coef(3'(gi), FRAC_W));
                    active_q <= COEF_W'(default_coef(3'(gi), FRAC_W));
                end else begin
                    if (coef_we_i && coef_idx_i == 3'(gi))
                        shadow_q <= coef_data_i;
                    if (accept)
                        active_q <= shadow_q;
                end
            end
            assign active_coef[gi] = active_q;
        end

        for (gi = 0; gi < CH; gi++) begin : g_hist
            logic signed [DATA_W-1:0] x1_q, x2_q, y1_q, y2_q;
            always_ff @(posedge clk_i) begin
                if (reset_i || flush_now) begin
                    x1_q <= '0;
                    x2_q <= '0;
                    y1_q <= '0;
                    y2_q <= '0;
                end else if (wb && ch_q == CH_W'(gi)) begin
                    x2_q <= x1_q;
                    x1_q <= x_q;
                    y2_q <= y1_q;
                    y1_q <= m_data_q;
                end
            end
            assign x1_rd[gi] = x1_q;
            assign x2_rd[gi] = x2_q;
            assign y1_rd[gi] = y1_q;
            assign y2_rd[gi] = y2_q;
        end
    endgenerate

    always_comb begin
        mac_coef = '0;
        mac_opnd = '0;
        mac_sub  = 1'b0;
        case (cnt_q)
            COEF_B0: begin mac_coef = active_coef[COEF_B0]; mac_opnd = x_q;          end
            COEF_B1: begin mac_coef = active_coef[COEF_B1]; mac_opnd = x1_rd[ch_q];  end
            COEF_B2: begin mac_coef = active_coef[COEF_B2]; mac_opnd = x2_rd[ch_q];  end
            COEF_A1: begin mac_coef = active_coef[COEF_A1]; mac_opnd = y1_rd[ch_q]; mac_sub = 1'b1; end
            COEF_A2: begin mac_coef = active_coef[COEF_A2]; mac_opnd = y2_rd[ch_q]; mac_sub = 1'b1; end
            default: ;
        endcase
    end

    biquad_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc_i  (acc_q),
        .coef_i (mac_coef),
        .data_i (mac_opnd),
        .sub_i  (mac_sub),
        .acc_o  (acc_sum),
        .y_o    (y_mac),
        .sat_o  (sat_mac)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (take) begin
                state_d = ST_MAC;
                cnt_d   = '0;
            end
            ST_MAC: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == COEF_A2)
                    state_d = ST_OUT;
            end
            ST_OUT: if (m_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            x_q          <= '0;
            ch_q         <= '0;
            bypass_q     <= 1'b0;
            flush_pend_q <= 1'b0;
            m_data_q     <= '0;
            m_ch_q       <= '0;
            sat_q        <= 1'b0;
            ch_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_err_q     <= accept && !ch_ok;
            flush_pend_q <= (state_q == ST_IDLE) ? 1'b0 : (flush_pend_q || flush_i);
            if (take) begin
                x_q      <= s_data_i;
                ch_q     <= s_ch_i;
                bypass_q <= bypass_i;
                acc_q    <= '0;
            end
            if (state_q == ST_MAC) begin
                acc_q <= acc_sum;
                // The a2 step completes the sum, so the output register loads straight from the MAC.
                if (cnt_q == COEF_A2) begin
                    m_data_q <= bypass_q ? x_q : y_mac;
                    sat_q    <= bypass_q ? 1'b0 : sat_mac;
                    m_ch_q   <= ch_q;
                end
            end
        end
    end

    assign s_ready_o = (state_q == ST_IDLE);
    assign m_valid_o = (state_q == ST_OUT);
    assign m_data_o  = m_data_q;
    assign m_ch_o    = m_ch_q;
    assign sat_o     = sat_q;
    assign ch_err_o  = ch_err_q;

endmodule

// File: tb/tb_biquad_notch_tdm.sv
// Self-checking bench for biquad_notch_tdm: directed cases then random traffic,
// all compared against an arithmetic reference model of the filter.
module tb_biquad_notch_tdm;
    localparam int TB_CH  = 5;
    localparam int DATA_W = 16;
    localparam int COEF_W = 18;
    localparam int FRAC_W = 14;
    localparam int CH_W   = 3;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              flush_i = 1'b0;
    logic              bypass_i = 1'b0;
    logic              coef_we_i = 1'b0;
    logic [2:0]        coef_idx_i = '0;
    logic [COEF_W-1:0] coef_data_i = '0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [DATA_W-1:0] s_data_i = '0;
    logic [CH_W-1:0]   s_ch_i = '0;
    logic              m_valid_o;
    logic              m_ready_i = 1'b1;
    logic [DATA_W-1:0] m_data_o;
    logic [CH_W-1:0]   m_ch_o;
    logic              sat_o;
    logic              ch_err_o;

    int n_vec = 0;
    int n_bad = 0;

    longint sh [5];
    longint act [5];
    longint hx1 [TB_CH];
    longint hx2 [TB_CH];
    longint hy1 [TB_CH];
    longint hy2 [TB_CH];

    always #5 clk_i = ~clk_i;

    biquad_notch_tdm #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W),
        .CH     (TB_CH)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .bypass_i    (bypass_i),
        .coef_we_i   (coef_we_i),
        .coef_idx_i  (coef_idx_i),
        .coef_data_i (coef_data_i),
        .s_valid_i   (s_valid_i),
        .s_ready_o   (s_ready_o),
        .s_data_i    (s_data_i),
        .s_ch_i      (s_ch_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .m_ch_o      (m_ch_o),
        .sat_o       (sat_o),
        .ch_err_o    (ch_err_o)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear_hist();
        for (int c = 0; c < TB_CH; c++) begin
            hx1[c] = 0; hx2[c] = 0; hy1[c] = 0; hy2[c] = 0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            sh[i]  = (i == 0) ? (64'sd1 <<< FRAC_W) : 0;
            act[i] = sh[i];
        end
        model_clear_hist();
    endtask

    // y = round_half_up(sum of coefficient products / 2^FRAC_W), clipped to 16 bits
    task automatic model_step(input int ch, input longint x, input bit byp,
                              output longint ey, output bit esat);
        longint acc, r;
        for (int i = 0; i < 5; i++) act[i] = sh[i];
        ey = 0;
        esat = 1'b0;
        if (ch >= TB_CH) return;
        acc = act[0] * x + act[1] * hx1[ch] + act[2] * hx2[ch]
            - act[3] * hy1[ch] - act[4] * hy2[ch];
        r = (acc + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
        if (r > 32767) begin
            r = 32767; esat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; esat = 1'b1;
        end
        if (byp) begin
            ey = x; esat = 1'b0;
        end else begin
            ey = r;
        end
        hx2[ch] = hx1[ch]; hx1[ch] = x;
        hy2[ch] = hy1[ch]; hy1[ch] = ey;
    endtask

    task automatic wr_coef(input int idx, input longint val);
        @(negedge clk_i);
        coef_we_i   = 1'b1;
        coef_idx_i  = 3'(idx);
        coef_data_i = COEF_W'(val);
        @(posedge clk_i);
        if (idx < 5) sh[idx] = val;
        @(negedge clk_i);
        coef_we_i = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        model_clear_hist();
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    // ev at the second cycle after acceptance: 1 = coef write, 2 = flush, 3 = reset
    task automatic send(input int ch, input int x, input bit byp, input int hold,
                        input int ev, input int ev_idx, input longint ev_val);
        longint ey;
        bit     esat;
        int     lat;
        @(negedge clk_i);
        chk("s_ready_idle", s_ready_o, 1);
        s_valid_i = 1'b1;
        s_data_i  = DATA_W'(x);
        s_ch_i    = CH_W'(ch);
        bypass_i  = byp;
        m_ready_i = (hold == 0);
        @(posedge clk_i);
        model_step(ch, longint'(x), byp, ey, esat);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        bypass_i  = 1'b0;
        if (ch >= TB_CH) begin
            chk("ch_err_pulse", ch_err_o, 1);
            for (int k = 0; k < 8; k++) begin
                chk("no_valid_bad_ch", m_valid_o, 0);
                @(negedge clk_i);
                chk("ch_err_one_cycle", ch_err_o, 0);
            end
            m_ready_i = 1'b1;
            $display("txn ch=%0d x=%0d invalid channel, no output", ch, x);
            return;
        end
        lat = 1;
        while (!m_valid_o && lat < 20) begin
            if (lat == 2 && ev == 3) begin
                reset_i = 1'b1;
                @(posedge clk_i);
                @(negedge clk_i);
                reset_i = 1'b0;
                chk("rst_mac_valid", m_valid_o, 0);
                chk("rst_mac_ready", s_ready_o, 1);
                chk("rst_mac_data", m_data_o, 0);
                model_reset();
                m_ready_i = 1'b1;
                $display("txn ch=%0d x=%0d reset during MAC", ch, x);
                return;
            end
            if (lat == 2 && ev == 1) begin
                coef_we_i   = 1'b1;
                coef_idx_i  = 3'(ev_idx);
                coef_data_i = COEF_W'(ev_val);
            end
            if (lat == 2 && ev == 2) flush_i = 1'b1;
            @(posedge clk_i);
            if (lat == 2 && ev == 1 && ev_idx < 5) sh[ev_idx] = ev_val;
            @(negedge clk_i);
            coef_we_i = 1'b0;
            flush_i   = 1'b0;
            lat++;
        end
        chk("latency", lat, 6);
        chk("data", $signed(m_data_o), ey);
        chk("ch", m_ch_o, ch);
        chk("sat", sat_o, esat);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk_i);
            chk("hold_valid", m_valid_o, 1);
            chk("hold_data", $signed(m_data_o), ey);
            chk("hold_sat", sat_o, esat);
            chk("hold_s_ready", s_ready_o, 0);
        end
        m_ready_i = 1'b1;
        @(posedge clk_i);
        if (ev == 2) model_clear_hist();
        $display("txn ch=%0d x=%0d byp=%0d hold=%0d ev=%0d y=%0d sat=%0d exp_y=%0d exp_sat=%0d",
                 ch, x, byp, hold, ev, $signed(m_data_o), sat_o, ey, esat);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_s_ready", s_ready_o, 1);
        chk("rst_m_data", m_data_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_ch_err", ch_err_o, 0);

        // pass-through defaults
        send(0, 1000, 0, 0, 0, 0, 0);
        send(0, -32768, 0, 0, 0, 0, 0);

        // two-tap FIR
        wr_coef(1, 16384);
        send(1, 100, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0, 0);
        send(1, 0, 0, 0, 0, 0, 0);

        // rounding and saturation
        wr_coef(1, 0);
        wr_coef(0, 8192);
        send(4, 3, 0, 0, 0, 0, 0);
        send(4, -3, 0, 0, 0, 0, 0);
        wr_coef(0, 65536);
        send(4, 20000, 0, 0, 0, 0, 0);
        send(4, -20000, 0, 0, 0, 0, 0);

        // recursive decay on ch2 with ch3 interleaved
        wr_coef(0, 16384);
        wr_coef(3, -8192);
        send(2, 1000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send(3, 0, 0, 0, 0, 0, 0);
            send(2, 0, 0, 0, 0, 0, 0);
        end

        // backpressure plus coefficient write during MAC
        wr_coef(3, 0);
        send(0, 1234, 0, 5, 1, 0, 0);
        send(0, 4321, 0, 0, 0, 0, 0);

        // flush, both immediate and pending
        wr_coef(0, 16384);
        wr_coef(1, 16384);
        send(0, 500, 0, 0, 0, 0, 0);
        do_flush();
        send(0, 700, 0, 0, 0, 0, 0);
        send(0, 300, 0, 0, 2, 0, 0);
        send(0, 900, 0, 0, 0, 0, 0);

        // bypass and invalid channel
        send(1, -1111, 1, 0, 0, 0, 0);
        send(5, 42, 0, 0, 0, 0, 0);

        // reset mid-MAC, then confirm history and coefficients are back to default
        send(0, 600, 0, 0, 0, 0, 0);
        send(0, 250, 0, 0, 3, 0, 0);
        wr_coef(1, 16384);
        send(0, 333, 0, 0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(9, 0));
            if (r == 0) begin
                wr_coef(int'($urandom_range(7, 0)), longint'(int'($urandom_range(65535, 0)) - 32768));
            end else if (r == 1) begin
                do_flush();
            end else begin
                send(int'($urandom_range(6, 0)),
                     int'($urandom_range(65535, 0)) - 32768,
                     ($urandom_range(3, 0) == 0),
                     int'($urandom_range(2, 0)),
                     int'($urandom_range(2, 0)),
                     int'($urandom_range(7, 0)),
                     longint'(int'($urandom_range(65535, 0)) - 32768));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
